// File: rtl/dbf_pkg.sv
// Shared types and helpers for the beamforming receive channel.
// DBF_FINE_INTERP_EN selects the interpolating 5-stage pipe (else 4 stages).
package dbf_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int unsigned DEF_INPUT_WD = 14;
  localparam int unsigned DEF_APO_WD   = 16;
  localparam int unsigned DEF_CD_WD    = 10;
  localparam int unsigned DEF_FD_WD    = 4;
  localparam int unsigned DEF_ADDR_WD  = 10;
  localparam int unsigned DEF_OUT_WD   = 32;

`ifdef DBF_FINE_INTERP_EN
  localparam int unsigned PIPE_LAT = 5;
`else
  localparam int unsigned PIPE_LAT = 4;
`endif

  // Round half up by 2**(shift-1), arithmetic shift, then clamp to a signed out_wd range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] p,
                                                   input int unsigned shift,
                                                   input int unsigned out_wd);
    logic signed [63:0] r;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    r  = (p + (64'sd1 <<< (shift - 1))) >>> shift;
    mx = (64'sd1 <<< (out_wd - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (r > mx)      round_sat = mx;
    else if (r < mn) round_sat = mn;
    else             round_sat = r;
  endfunction

endpackage

// File: rtl/dbf_ch_param_delay_line.sv
// Circular sample buffer: one write port, two registered read ports with underflow zeroing.
// Built identically with or without DBF_FINE_INTERP_EN.
module dbf_delay_line #(
  parameter int unsigned INPUT_WD = 14,
  parameter int unsigned CD_WD    = 10
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [CD_WD-1:0]           waddr,
  input  logic signed [INPUT_WD-1:0] wdata,
  input  logic [CD_WD-1:0]           raddr_a,
  input  logic [CD_WD-1:0]           raddr_b,
  input  logic                       zero_a,
  input  logic                       zero_b,
  output logic signed [INPUT_WD-1:0] a_q,
  output logic signed [INPUT_WD-1:0] b_q
);

  logic signed [INPUT_WD-1:0] mem [2**CD_WD];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reads trail the write by one stage, so c=0 already sees the newest sample; a read that
  // collides with the following write still returns the older sample it refers to.
  always_ff @(posedge clk) begin
    a_q <= zero_a ? '0 : mem[raddr_a];
    b_q <= zero_b ? '0 : mem[raddr_b];
  end

endmodule

// File: rtl/dbf_ch_param.sv
// Beamforming receive channel: coarse delay, fine interpolation, apodisation, round/saturate.
// DBF_FINE_INTERP_EN enables 2-tap interpolation (S3); otherwise y = a and latency is 4.
module dbf_ch_param
  import dbf_pkg::*;
#(
  parameter int unsigned INPUT_WD = DEF_INPUT_WD,
  parameter int unsigned APO_WD   = DEF_APO_WD,
  parameter int unsigned CD_WD    = DEF_CD_WD,
  parameter int unsigned FD_WD    = DEF_FD_WD,
  parameter int unsigned ADDR_WD  = DEF_ADDR_WD,
  parameter int unsigned OUT_WD   = DEF_OUT_WD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_en,
  input  logic                       start,
  input  logic [ADDR_WD-1:0]         line_len,
  input  logic signed [INPUT_WD-1:0] ch_in,
  input  logic                       ch_in_valid,
  input  logic signed [APO_WD-1:0]   apo_din,
  input  logic [ADDR_WD-1:0]         lut_addr,
  input  logic                       lut_we,
  input  logic [CD_WD+FD_WD-1:0]     lut_wdata,
  output logic signed [OUT_WD-1:0]   dbf_dout,
  output logic                       dbf_dout_valid,
  output logic                       busy
);

  localparam int unsigned LUT_WD = CD_WD + FD_WD;
  localparam int unsigned Y_WD   = INPUT_WD + 1;
  localparam int unsigned P_WD   = Y_WD + APO_WD;

  state_t             state, state_nx;
  logic               accept, flush, line_end, drain_done;
  logic [CD_WD-1:0]   wr_ptr, fill;
  logic [ADDR_WD-1:0] zone;
  logic [2:0]         drain_cnt;

  assign accept     = (state == RUN) && ch_in_valid && !tx_en;
  assign flush      = tx_en && (state != IDLE);
  assign line_end   = accept && (zone == line_len);
  assign drain_done = (drain_cnt == 3'(PIPE_LAT - 1));
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !tx_en) state_nx = RUN;
      RUN:     if (tx_en) state_nx = IDLE;
               else if (line_end) state_nx = DRAIN;
      DRAIN:   if (tx_en || drain_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      zone      <= '0;
      fill      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : '0;
      if (state == IDLE && start && !tx_en) begin
        wr_ptr <= '0;
        zone   <= '0;
        fill   <= '0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + CD_WD'(1);
        zone   <= zone + ADDR_WD'(1);
        fill   <= (fill == '1) ? fill : fill + CD_WD'(1);
      end
    end
  end

  // Focal LUT: registered read, so a same-cycle write to the read address returns old data.
  logic [LUT_WD-1:0] lut [2**ADDR_WD];
  logic [LUT_WD-1:0] lut_q;

  always_ff @(posedge clk) begin
    if (lut_we) lut[lut_addr] <= lut_wdata;
    lut_q <= lut[zone];
  end

  // S1: sample written, LUT entry fetched, context captured.
  logic                     s1_v;
  logic [CD_WD-1:0]         s1_ptr, s1_fill;
  logic signed [APO_WD-1:0] s1_apo;

  always_ff @(posedge clk) begin
    if (rst || flush) s1_v <= 1'b0;
    else              s1_v <= accept;
    if (accept) begin
      s1_ptr  <= wr_ptr;
      s1_fill <= fill;
      s1_apo  <= apo_din;
    end
  end

  // S2: delayed taps read from the buffer.
  logic [CD_WD-1:0]           coarse, raddr_a, raddr_b;
  logic [FD_WD-1:0]           fine;
  logic                       zero_a, zero_b;
  logic signed [INPUT_WD-1:0] a_q, b_q;
  logic                       s2_v;
  logic signed [APO_WD-1:0]   s2_apo;

  assign coarse  = lut_q[LUT_WD-1:FD_WD];
  assign fine    = lut_q[FD_WD-1:0];
  assign raddr_a = s1_ptr - coarse;
  assign raddr_b = s1_ptr - coarse - CD_WD'(1);
  assign zero_a  = (coarse > s1_fill);
  assign zero_b  = (({1'b0, coarse} + (CD_WD + 1)'(1)) > {1'b0, s1_fill});

  dbf_delay_line #(
    .INPUT_WD(INPUT_WD),
    .CD_WD   (CD_WD)
  ) u_delay_line (
    .clk    (clk),
    .we     (accept),
    .waddr  (wr_ptr),
    .wdata  (ch_in),
    .raddr_a(raddr_a),
    .raddr_b(raddr_b),
    .zero_a (zero_a),
    .zero_b (zero_b),
    .a_q    (a_q),
    .b_q    (b_q)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) s2_v <= 1'b0;
    else              s2_v <= s1_v;
    s2_apo <= s1_apo;
  end

  // S3: interpolated sample y.
  logic signed [Y_WD-1:0]   y_q;
  logic                     s3_v;
  logic signed [APO_WD-1:0] s3_apo;

`ifdef DBF_FINE_INTERP_EN
  localparam int unsigned ACC_WD = INPUT_WD + FD_WD + 1;

  logic [FD_WD-1:0]         s2_f;
  logic signed [ACC_WD-1:0] a_s, b_s, wa_s, wb_s, acc;
  logic                     unused_acc_lsb;

  always_ff @(posedge clk) begin
    s2_f <= fine;
  end

  always_comb begin
    a_s  = ACC_WD'(a_q);
    b_s  = ACC_WD'(b_q);
    wa_s = ACC_WD'((FD_WD + 1)'(2**FD_WD) - (FD_WD + 1)'(s2_f));
    wb_s = ACC_WD'(s2_f);
    acc  = a_s * wa_s + b_s * wb_s + ACC_WD'(2**(FD_WD - 1));
  end

  assign unused_acc_lsb = ^acc[FD_WD-1:0];

  always_ff @(posedge clk) begin
    if (rst || flush) s3_v <= 1'b0;
    else              s3_v <= s2_v;
    y_q    <= acc[FD_WD +: Y_WD];
    s3_apo <= s2_apo;
  end
`else
  logic unused_fine;

  assign unused_fine = ^{fine, b_q};

  always_comb begin
    y_q    = Y_WD'(a_q);
    s3_v   = s2_v;
    s3_apo = s2_apo;
  end
`endif

  // S4: apodisation product.
  logic signed [P_WD-1:0] p_q;
  logic                   s4_v;

  always_ff @(posedge clk) begin
    if (rst || flush) s4_v <= 1'b0;
    else              s4_v <= s3_v;
    p_q <= P_WD'(y_q) * P_WD'(s3_apo);
  end

  // S5: round/saturate; output holds its value between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbf_dout       <= '0;
      dbf_dout_valid <= 1'b0;
    end else begin
      dbf_dout_valid <= s4_v && !flush;
      if (s4_v && !flush)
        dbf_dout <= OUT_WD'(round_sat(64'(p_q), APO_WD - 1, OUT_WD));
    end
  end

endmodule

// File: tb/tb_dbf_ch_param.sv
// Self-checking bench for dbf_ch_param (32-bit and 14-bit output instances, shared stimulus).
module tb_dbf_ch_param;

`ifdef DBF_FINE_INTERP_EN
  localparam int LAT  = 5;
  localparam bit FINE = 1'b1;
`else
  localparam int LAT  = 4;
  localparam bit FINE = 1'b0;
`endif
  localparam int DEPTH = 1024;

  logic               clk, rst, tx_en, start, ch_in_valid, lut_we;
  logic [9:0]         line_len, lut_addr;
  logic signed [13:0] ch_in;
  logic signed [15:0] apo_din;
  logic [13:0]        lut_wdata;
  logic signed [31:0] dout32;
  logic signed [13:0] dout14;
  logic               v32, v14, busy32, busy14;

  dbf_ch_param u_dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .start(start), .line_len(line_len),
    .ch_in(ch_in), .ch_in_valid(ch_in_valid), .apo_din(apo_din),
    .lut_addr(lut_addr), .lut_we(lut_we), .lut_wdata(lut_wdata),
    .dbf_dout(dout32), .dbf_dout_valid(v32), .busy(busy32)
  );

  dbf_ch_param #(.OUT_WD(14)) u_sat (
    .clk(clk), .rst(rst), .tx_en(tx_en), .start(start), .line_len(line_len),
    .ch_in(ch_in), .ch_in_valid(ch_in_valid), .apo_din(apo_din),
    .lut_addr(lut_addr), .lut_we(lut_we), .lut_wdata(lut_wdata),
    .dbf_dout(dout14), .dbf_dout_valid(v14), .busy(busy14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: history of samples since start, expected results tagged with due edge.
  typedef struct { int due; int v32; int v14; } exp_t;
  exp_t expq[$];
  int   hist[$];
  int   lut_m [DEPTH];
  int   cyc = 0;
  bit   m_run = 0;
  int   m_drain = 0;
  int   m_nacc = 0;
  int   hold32 = 0, hold14 = 0;

  always @(posedge clk) begin
    int n, fl, c, f, a, b, y, p, r;
    bit idle_b;
    exp_t e;
    cyc++;
    if (rst) begin
      m_run = 0; m_drain = 0; expq.delete(); hold32 = 0; hold14 = 0;
    end else begin
      idle_b = !m_run && (m_drain == 0);
      if (tx_en && !idle_b) begin
        m_run = 0; m_drain = 0; expq.delete();
      end else if (m_run && ch_in_valid) begin
        hist.push_back(int'(ch_in));
        n  = hist.size() - 1;
        fl = (n < DEPTH - 1) ? n : DEPTH - 1;
        c  = lut_m[m_nacc % DEPTH] >> 4;
        f  = lut_m[m_nacc % DEPTH] & 15;
        a  = (c <= fl) ? hist[n - c] : 0;
        b  = (c + 1 <= fl) ? hist[n - c - 1] : 0;
        y  = FINE ? ((a * (16 - f) + b * f + 8) >>> 4) : a;
        p  = y * int'(apo_din);
        r  = (p + 16384) >>> 15;
        e.due = cyc + LAT - 1;
        e.v32 = r;
        e.v14 = (r > 8191) ? 8191 : ((r < -8192) ? -8192 : r);
        expq.push_back(e);
        m_nacc++;
        if (m_nacc - 1 == int'(line_len)) begin m_run = 0; m_drain = LAT; end
      end else if (m_drain > 0) begin
        m_drain--;
      end
      if (idle_b && start && !tx_en) begin
        m_run = 1; m_nacc = 0; hist.delete();
      end
    end
    if (lut_we) lut_m[lut_addr] = int'(lut_wdata);
  end

  // Compare process plus capture for the directed checks.
  int got32 [64];
  int got14 [64];
  int ng = 0;
  int first_valid_edge = -1;
  int fall_edge = -1;
  bit busy_prev = 0;
  bit exp_v;

  always @(negedge clk) begin
    exp_v = 1'b0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      exp_v  = 1'b1;
      hold32 = expq[0].v32;
      hold14 = expq[0].v14;
      void'(expq.pop_front());
    end
    check("valid32", int'(v32), int'(exp_v));
    check("dout32", int'(dout32), hold32);
    check("valid14", int'(v14), int'(exp_v));
    check("dout14", int'(dout14), hold14);
    check("busy32", int'(busy32), int'(m_run || m_drain > 0));
    check("busy14", int'(busy14), int'(m_run || m_drain > 0));
    if (v32) begin
      if (ng < 64) begin got32[ng] = int'(dout32); got14[ng] = int'(dout14); end
      if (ng == 0) first_valid_edge = cyc;
      ng++;
    end
    if (busy_prev && !busy32) fall_edge = cyc;
    busy_prev = busy32;
  end

  int sx [64];
  int sa [64];
  int edge_of [64];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_lut(input int c, input int f, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      lut_we = 1'b1; lut_addr = 10'(i); lut_wdata = 14'((c << 4) | f);
      tick();
    end
    lut_we = 1'b0;
  endtask

  task automatic start_line(input int len);
    ng = 0; first_valid_edge = -1; fall_edge = -1;
    line_len = 10'(len - 1);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      ch_in_valid = 1'b1; ch_in = 14'(sx[i]); apo_din = 16'(sa[i]);
      tick();
      edge_of[i] = cyc;
    end
    ch_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy32 && k < 200) begin tick(); k++; end
    check(nm, int'(busy32), 0);
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1; tx_en = 1'b0; start = 1'b0; ch_in_valid = 1'b0; lut_we = 1'b0;
    line_len = '0; lut_addr = '0; ch_in = '0; apo_din = '0; lut_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_dout", int'(dout32), 0);
    check("reset_valid", int'(v32), 0);
    check("reset_busy", int'(busy32), 0);

    // Ramp through a 3-sample coarse delay at full-scale weight.
    load_lut(3, 0, 16);
    for (int i = 0; i < 12; i++) begin sx[i] = i + 1; sa[i] = 32767; end
    start_line(12);
    feed(12);
    wait_idle("ramp_idle");
    check("ramp_count", ng, 12);
    check("ramp_o0", got32[0], 0);
    check("ramp_o2", got32[2], 0);
    check("ramp_o3", got32[3], 1);
    check("ramp_o4", got32[4], 2);
    check("ramp_o11", got32[11], 9);
    check("ramp_latency", first_valid_edge - edge_of[0], LAT - 1);

    // Half-sample fine delay on an alternating 100/200 input.
    load_lut(0, 8, 8);
    for (int i = 0; i < 6; i++) begin sx[i] = (i % 2 == 0) ? 100 : 200; sa[i] = 32767; end
    start_line(6);
    feed(6);
    wait_idle("alt_idle");
    check("alt_count", ng, 6);
    check("alt_o0", got32[0], FINE ? 50 : 100);
    check("alt_o1", got32[1], FINE ? 150 : 200);
    check("alt_o4", got32[4], FINE ? 150 : 100);

    // Saturation and half-weight rounding.
    load_lut(0, 0, 4);
    sx[0] = -8192; sa[0] = -32768;
    sx[1] = 101;   sa[1] = 16384;
    sx[2] = -101;  sa[2] = 16384;
    start_line(3);
    feed(3);
    wait_idle("sat_idle");
    check("sat_o32", got32[0], 8192);
    check("sat_o14", got14[0], 8191);
    check("half_pos", got32[1], 51);
    check("half_neg", got32[2], -50);

    // line_len=9 with extra samples past the end of the line.
    load_lut(2, 4, 16);
    for (int i = 0; i < 14; i++) begin sx[i] = i * 37 - 200; sa[i] = 20000 - i * 3000; end
    start_line(10);
    feed(14);
    wait_idle("len_idle");
    check("len_count", ng, 10);
    check("len_busy_fall", fall_edge - edge_of[9], LAT);
    check("len_o2", got32[2], FINE ? -64 : -85);
    feed(4);
    tick(); tick(); tick(); tick(); tick(); tick();
    check("idle_ignored", ng, 10);

    // tx_en abort mid-line, then a clean restart.
    load_lut(1, 3, 32);
    for (int i = 0; i < 20; i++) begin sx[i] = i * 10 + 5; sa[i] = 32767; end
    start_line(20);
    feed(6);
    ch_in_valid = 1'b1; tx_en = 1'b1;
    tick();
    check("abort_valid", int'(v32), 0);
    check("abort_busy", int'(busy32), 0);
    tx_en = 1'b0;
    repeat (8) tick();
    ch_in_valid = 1'b0;
    check("abort_no_more", ng, LAT == 5 ? 2 : 3);
    start_line(4);
    feed(4);
    wait_idle("restart_idle");
    check("restart_count", ng, 4);

    // Reset pulse mid-line.
    start_line(20);
    feed(7);
    rst = 1'b1;
    tick();
    check("rst_dout32", int'(dout32), 0);
    check("rst_dout14", int'(dout14), 0);
    check("rst_valid", int'(v32), 0);
    check("rst_busy", int'(busy32), 0);
    rst = 1'b0;
    tick();
    start_line(3);
    feed(3);
    wait_idle("post_rst_idle");
    check("post_rst_count", ng, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
